// File: rtl/packet_buffer.sv
// packet_buffer: byte FIFO with per-packet commit/rewind plus a length FIFO.
// The length FIFO feeds a framed output stream (outStart/outEnd/outLength).
// Only committed packets are readable. Dropped packets are rewound to their
// start pointer, so none of their bytes reach the output.
// Optional feature: define PACKET_BUFFER_LENCHECK_EN to also drop a packet
// whose declared sourceDataSize differs from the number of bytes received.
module packet_buffer #(
   parameter int DATA_DEPTH_LOG2 = 8,
   parameter int LEN_DEPTH_LOG2  = 4
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic [7:0] sourceData,
   input  logic       sourceDataValid,
   input  logic [7:0] sourceDataSize,
   input  logic       sourceDataSizeValid,
   output logic [7:0] outData,
   output logic       outValid,
   input  logic       outReady,
   output logic       outStart,
   output logic       outEnd,
   output logic [7:0] outLength,
   output logic [7:0] pktCount,
   output logic [7:0] dropCount
);

   localparam int DATA_DEPTH = 1 << DATA_DEPTH_LOG2;
   localparam int LEN_DEPTH  = 1 << LEN_DEPTH_LOG2;

   typedef logic [DATA_DEPTH_LOG2:0] dptr_t;
   typedef logic [LEN_DEPTH_LOG2:0]  lptr_t;

   localparam dptr_t DPTR_ONE = dptr_t'(1);
   localparam lptr_t LPTR_ONE = lptr_t'(1);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      STREAM
   } state_t;

   logic [7:0] data_mem [DATA_DEPTH];
   logic [7:0] len_mem  [LEN_DEPTH];

   dptr_t      wr_ptr;
   dptr_t      rd_ptr;
   dptr_t      start_ptr;
   dptr_t      base_ptr;
   lptr_t      len_wr;
   lptr_t      len_rd;
   logic [7:0] rx_count;
   logic [7:0] remaining;
   logic       dropped;

   logic       len_full;
   logic       len_empty;
   logic       len_pop;
   logic       commit;
   logic       size_bad;
   logic       data_full;
   logic       byte_write;
   logic       byte_drop;
   logic       xfer;

   state_t     state;
   state_t     state_next;

   assign len_empty = (len_wr == len_rd);
   assign len_full  = (len_wr[LEN_DEPTH_LOG2] != len_rd[LEN_DEPTH_LOG2]) &&
                      (len_wr[LEN_DEPTH_LOG2-1:0] == len_rd[LEN_DEPTH_LOG2-1:0]);

`ifdef PACKET_BUFFER_LENCHECK_EN
   assign size_bad = (sourceDataSize != rx_count);
`else
   logic size_unused;
   assign size_bad    = 1'b0;
   assign size_unused = ^sourceDataSize;
`endif

   // Ingress decision: commit or drop on close, and where an incoming byte lands.
   // A byte arriving with the close belongs to the next packet, so it is placed
   // at the post-close write pointer (rewound start pointer if the close drops).
   always_comb begin
      commit   = 1'b0;
      base_ptr = wr_ptr;
      if (sourceDataSizeValid) begin
         commit = !dropped && (rx_count != 8'd0) && !size_bad &&
                  (!len_full || len_pop);
         if (!commit) begin
            base_ptr = start_ptr;
         end
      end
      data_full  = (base_ptr[DATA_DEPTH_LOG2] != rd_ptr[DATA_DEPTH_LOG2]) &&
                   (base_ptr[DATA_DEPTH_LOG2-1:0] == rd_ptr[DATA_DEPTH_LOG2-1:0]);
      byte_write = sourceDataValid && !data_full;
      byte_drop  = sourceDataValid && data_full;
   end

   // Ingress state: write pointer, packet start, byte count, drop flag, counters.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         wr_ptr    <= '0;
         start_ptr <= '0;
         rx_count  <= '0;
         dropped   <= 1'b0;
         len_wr    <= '0;
         pktCount  <= '0;
         dropCount <= '0;
      end else if (sourceDataSizeValid) begin
         if (commit) begin
            len_wr    <= len_wr + LPTR_ONE;
            start_ptr <= wr_ptr;
            pktCount  <= pktCount + 8'd1;
         end else if (dropCount != 8'hFF) begin
            dropCount <= dropCount + 8'd1;
         end
         wr_ptr   <= byte_write ? base_ptr + DPTR_ONE : base_ptr;
         rx_count <= byte_write ? 8'd1 : 8'd0;
         dropped  <= byte_drop;
      end else begin
         if (byte_write) begin
            wr_ptr   <= wr_ptr + DPTR_ONE;
            rx_count <= rx_count + 8'd1;
         end
         if (byte_drop) begin
            dropped <= 1'b1;
         end
      end
   end

   // Storage writes: packet bytes and committed lengths.
   always_ff @(posedge CLK) begin
      if (byte_write) begin
         data_mem[base_ptr[DATA_DEPTH_LOG2-1:0]] <= sourceData;
      end
      if (commit) begin
         len_mem[len_wr[LEN_DEPTH_LOG2-1:0]] <= rx_count;
      end
   end

   // Output FSM state register.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Output FSM next state and stream outputs; outputs are zero outside STREAM.
   always_comb begin
      state_next = state;
      len_pop    = 1'b0;
      xfer       = 1'b0;
      outValid   = 1'b0;
      outData    = '0;
      outStart   = 1'b0;
      outEnd     = 1'b0;
      case (state)
         IDLE: begin
            if (!len_empty) begin
               state_next = LOAD;
            end
         end
         LOAD: begin
            len_pop    = 1'b1;
            state_next = STREAM;
         end
         STREAM: begin
            outValid = 1'b1;
            outData  = data_mem[rd_ptr[DATA_DEPTH_LOG2-1:0]];
            outStart = (remaining == outLength);
            outEnd   = (remaining == 8'd1);
            xfer     = outReady;
            if (outReady && (remaining == 8'd1)) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Egress datapath: length pop into outLength/remaining, read pointer advance.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         rd_ptr    <= '0;
         len_rd    <= '0;
         outLength <= '0;
         remaining <= '0;
      end else begin
         if (len_pop) begin
            outLength <= len_mem[len_rd[LEN_DEPTH_LOG2-1:0]];
            remaining <= len_mem[len_rd[LEN_DEPTH_LOG2-1:0]];
            len_rd    <= len_rd + LPTR_ONE;
         end
         if (xfer) begin
            rd_ptr    <= rd_ptr + DPTR_ONE;
            remaining <= remaining - 8'd1;
         end
      end
   end

endmodule
